// File: rtl/display_scan.sv
// rtl/display_scan.sv - serial binary-to-BCD seven-segment scanner; optional signed mode via DISPLAY_SCAN_SIGNED_EN
module display_scan #(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);
    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(DATA_W + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNTW = $clog2(SCAN_DIV);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   sh;
    logic [BW:0]         work, work_nxt;
    logic [BW-1:0]       adj;
    logic [BW:0]         shifted;
    logic [CW-1:0]       bitcnt;
    logic                last;
    logic [BW-1:0]       disp;
    logic [DATA_W-1:0]   mag;
    logic [CNTW-1:0]     cnt;
    logic [IW-1:0]       idx, msd;
    logic [3:0]          cur;
    logic [6:0]          glyph;
`ifdef DISPLAY_SCAN_SIGNED_EN
    logic                neg, disp_neg;
`endif

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = BLANK;
        endcase
    endfunction

    assign last = (bitcnt == CW'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state == CONV);
        case (state)
            IDLE: if (load) state_nxt = CONV;
            CONV: if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DISPLAY_SCAN_SIGNED_EN
    // Magnitude is taken as DATA_W-bit unsigned so the most negative value survives.
    assign mag = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
`else
    assign mag = value;
`endif

    // One shift-add-3 step; the carry bit is sticky across the whole conversion.
    always_comb begin
        adj = work[BW-1:0];
        for (int i = 0; i < DIGITS; i++)
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        shifted  = {adj, sh[DATA_W-1]};
        work_nxt = {work[BW] | shifted[BW], shifted[BW-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            work   <= '0;
            bitcnt <= '0;
            disp   <= '0;
            ovf    <= 1'b0;
`ifdef DISPLAY_SCAN_SIGNED_EN
            neg      <= 1'b0;
            disp_neg <= 1'b0;
`endif
        end else if (state == IDLE && load) begin
            sh     <= mag;
            work   <= '0;
            bitcnt <= '0;
`ifdef DISPLAY_SCAN_SIGNED_EN
            neg    <= value[DATA_W-1];
`endif
        end else if (state == CONV) begin
            sh     <= sh << 1;
            work   <= work_nxt;
            bitcnt <= bitcnt + CW'(1);
            if (last) begin
                disp <= work_nxt[BW-1:0];
`ifdef DISPLAY_SCAN_SIGNED_EN
                // A full-width magnitude leaves no room for the sign digit.
                ovf      <= work_nxt[BW] | (|work_nxt[BW-1 -: 4]);
                disp_neg <= neg;
`else
                ovf  <= work_nxt[BW];
`endif
            end
        end
    end

    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++)
            if (disp[4*i +: 4] != 4'd0) msd = IW'(i);
        cur   = disp[4*idx +: 4];
        glyph = BLANK;
        if (ovf)
            glyph = DASH;
        else if (idx <= msd)
            glyph = seg_code(cur);
`ifdef DISPLAY_SCAN_SIGNED_EN
        else if (disp_neg && ({1'b0, idx} == {1'b0, msd} + (IW+1)'(1)))
            glyph = DASH;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
            seg <= BLANK;
            an  <= '1;
        end else begin
            if (cnt == CNTW'(SCAN_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CNTW'(1);
            end
            seg <= (cnt == '0) ? BLANK : glyph;
            an  <= (cnt == '0) ? '1 : ~(DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - table-driven bench for display_scan (DIGITS=4 and DIGITS=2 instances)
module tb_display_scan;
    localparam logic [6:0] B  = 7'h7F, D  = 7'b0111111;
    localparam logic [6:0] C0 = 7'b1000000, C1 = 7'b1111001, C2 = 7'b0100100, C3 = 7'b0110000;
    localparam logic [6:0] C4 = 7'b0011001, C5 = 7'b0010010, C6 = 7'b0000010, C7 = 7'b1111000;
    localparam logic [6:0] C8 = 7'b0000000, C9 = 7'b0010000;

    logic       clk = 1'b0, rst_n = 1'b0, load = 1'b0;
    logic [7:0] value = 8'd0;
    logic       busy, ovf, busy2, ovf2;
    logic [6:0] seg, seg2;
    logic [3:0] an;
    logic [1:0] an2;

    int checks = 0, failures = 0;
    logic [6:0] got4 [4];
    logic [6:0] got2 [2];

    typedef struct {
        logic [7:0]  v;
        logic [27:0] d4;
        logic        o4;
        logic [13:0] d2;
        logic        o2;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    display_scan #(.DIGITS(4), .DATA_W(8), .SCAN_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy), .ovf(ovf), .seg(seg), .an(an));

    display_scan #(.DIGITS(2), .DATA_W(8), .SCAN_DIV(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy2), .ovf(ovf2), .seg(seg2), .an(an2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        int n;
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        chk("busy_cycles", n, 8);
    endtask

    // Record the segment pattern seen on each lit anode across two full frames.
    task automatic capture();
        for (int i = 0; i < 4; i++) got4[i] = 7'h55;
        for (int i = 0; i < 2; i++) got2[i] = 7'h55;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (!an[i]) got4[i] = seg;
            for (int i = 0; i < 2; i++) if (!an2[i]) got2[i] = seg2;
        end
    endtask

    initial begin
        int n, all_high, multi;
        int lit [4];

`ifdef DISPLAY_SCAN_SIGNED_EN
        tbl[0] = '{8'hFB, {B, B, D, C5},    1'b0, {D, C5},  1'b0};
        tbl[1] = '{8'h80, {D, C1, C2, C8},  1'b0, {D, D},   1'b1};
        tbl[2] = '{8'd7,  {B, B, B, C7},    1'b0, {B, C7},  1'b0};
        tbl[3] = '{8'hF6, {B, D, C1, C0},   1'b0, {D, D},   1'b1};
        tbl[4] = '{8'd0,  {B, B, B, C0},    1'b0, {B, C0},  1'b0};
        tbl[5] = '{8'd5,  {B, B, B, C5},    1'b0, {B, C5},  1'b0};
        tbl[6] = '{8'hFF, {B, B, D, C1},    1'b0, {D, C1},  1'b0};
        tbl[7] = '{8'd9,  {B, B, B, C9},    1'b0, {B, C9},  1'b0};
`else
        tbl[0] = '{8'd255, {B, C2, C5, C5}, 1'b0, {D, D},   1'b1};
        tbl[1] = '{8'd0,   {B, B, B, C0},   1'b0, {B, C0},  1'b0};
        tbl[2] = '{8'd9,   {B, B, B, C9},   1'b0, {B, C9},  1'b0};
        tbl[3] = '{8'd10,  {B, B, C1, C0},  1'b0, {C1, C0}, 1'b0};
        tbl[4] = '{8'd100, {B, C1, C0, C0}, 1'b0, {D, D},   1'b1};
        tbl[5] = '{8'd42,  {B, B, C4, C2},  1'b0, {C4, C2}, 1'b0};
        tbl[6] = '{8'd208, {B, C2, C0, C8}, 1'b0, {D, D},   1'b1};
        tbl[7] = '{8'd63,  {B, B, C6, C3},  1'b0, {C6, C3}, 1'b0};
`endif

        repeat (2) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, B);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_blank_an", an, 4'hF);
        @(negedge clk);
        chk("first_lit_an", an, 4'b1110);
        chk("first_lit_seg", seg, C0);

        // Scan pattern over four frames.
        all_high = 0;
        multi = 0;
        for (int i = 0; i < 4; i++) lit[i] = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (an == 4'hF) all_high++;
            if ($countones(~an) > 1) multi++;
            for (int i = 0; i < 4; i++) if (!an[i]) lit[i]++;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("lit_cycles_%0d", i), lit[i], 12);
        chk("blank_cycles", all_high, 16);
        chk("multi_anode", multi, 0);

        for (int k = 0; k < 8; k++) begin
            do_load(tbl[k].v);
            capture();
            chk($sformatf("digits4_v%0d", tbl[k].v), {got4[3], got4[2], got4[1], got4[0]}, tbl[k].d4);
            chk($sformatf("ovf4_v%0d", tbl[k].v), ovf, tbl[k].o4);
            chk($sformatf("digits2_v%0d", tbl[k].v), {got2[1], got2[0]}, tbl[k].d2);
            chk($sformatf("ovf2_v%0d", tbl[k].v), ovf2, tbl[k].o2);
        end

        // A load during conversion is dropped.
        @(negedge clk);
        value = 8'd7;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        value = 8'd99;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        chk("busy_done_lwb", busy, 0);
        capture();
        chk("load_while_busy", {got4[3], got4[2], got4[1], got4[0]}, {B, B, B, C7});

        // Holding load converts back to back with a single idle cycle between.
        @(negedge clk);
        value = 8'd12;
        load  = 1'b1;
        @(negedge clk);
        value = 8'd34;
        n = 0;
        for (int s = 0; s < 8; s++) begin
            if (busy) n++;
            @(negedge clk);
        end
        chk("b2b_busy_high", n, 8);
        chk("b2b_gap", busy, 0);
        @(negedge clk);
        load = 1'b0;
        chk("b2b_restart", busy, 1);
        wait_idle(n);
        chk("b2b_len", n, 8);
        capture();
        chk("b2b_digits", {got4[3], got4[2], got4[1], got4[0]}, {B, B, C3, C4});

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        value = 8'd123;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, B);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_blank_an", an, 4'hF);
        @(negedge clk);
        chk("rel_lit_an", an, 4'b1110);
        chk("rel_lit_seg", seg, C0);
        capture();
        chk("rst_digits", {got4[3], got4[2], got4[1], got4[0]}, {B, B, B, C0});
        chk("rst_ovf2", ovf2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_scan.md
# display_scan

Parametrised multi-digit seven-segment display driver for the lab computer top level. It accepts a binary value over a load/busy handshake and converts it to BCD serially with shift-add-3, one bit per cycle. It then time-multiplexes the digits onto a shared active-low segment bus, with anti-ghost blanking and leading-zero suppression. It replaces the fixed 4-digit `i%16` scan logic and the combinational `BCD` path.

## Interface
- `DIGITS`, default 4: number of digits/anodes, 1..8.
- `DATA_W`, default 8: width of `value`, 1..26.
- `SCAN_DIV`, default 4: clock cycles per digit slot, at least 2.

- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `value`, input, DATA_W: binary value to display.
- `load`, input, 1: request to capture `value`. Sampled on `clk`.
- `busy`, output, 1: conversion in progress. `load` is ignored while high.
- `ovf`, output, 1: the last converted value does not fit in DIGITS digits.
- `seg`, output, 7: active-low segments, bit order gfedcba (bit 6 = g).
- `an`, output, DIGITS: active-low anodes. `an[0]` is the rightmost digit.

## Operation
- **States:**
  - IDLE: `busy`=0.
  - CONV: `busy`=1, runs for DATA_W cycles.
- **IDLE to CONV:** `load`=1 at an edge while in IDLE captures `value` and zeroes the working BCD register. The working register is 4*DIGITS bits plus a carry bit.
- **CONV step, each cycle:**
  - For every BCD nibble of 5 or more, add 3.
  - Shift left, bringing in the next captured bit, MSB first.
  - A 1 shifted out of the top nibble sets the sticky overflow bit.
- **CONV to IDLE:** after the DATA_W-th shift, the display digit registers and `ovf` are updated in one atomic transfer, then the block returns to IDLE. The display never shows a partial result.
- **`load` during CONV:** ignored, not queued.
- **Leading-zero suppression:** digits above the most significant nonzero digit are blank (7'h7F). Digit 0 is always shown, so zero displays as "0".
- **Overflow:** `ovf`=1 drives every digit to '-' (7'b0111111).
- **Segment codes (gfedcba, active-low):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- **Scanner:**
  - Free-running slot counter `cnt` runs 0..SCAN_DIV-1.
  - On `cnt` wrap, digit index `idx` advances 0..DIGITS-1 and wraps to 0.
  - In the slot cycle where `cnt`=0: `an` is all ones and `seg`=7'h7F (anti-ghost blank).
  - In slot cycles with `cnt`≥1: `an[idx]`=0 and `seg` carries the code for digit `idx`.
- **Reset (`rst_n`=0, async):**
  - `busy`=0, `ovf`=0, state IDLE.
  - Digit registers cleared, so the display shows "0".
  - `cnt`=0, `idx`=0.
  - `an` all ones, `seg`=7'h7F.
- **Reset during CONV:** aborts the conversion. No digit update occurs.

## Timing
- `load` accepted at edge N:
  - `busy` is high from edge N through edge N+DATA_W.
  - `busy` falls and the new digits/`ovf` are visible after edge N+DATA_W.
  - Next `load` can be accepted at edge N+DATA_W+1.
- Back-to-back: holding `load` high converts the value present at each acceptance edge. One conversion per DATA_W+1 cycles.
- `seg`/`an` are registered: they reflect the `(idx,cnt)` values sampled at the previous edge.
- Frame period: DIGITS*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-1 cycles per frame.
- The first lit cycle after reset release is digit 0, one slot cycle after the initial blank.
- New digit data takes effect on the next lit cycle. The scan phase is never reset by `load`.

## Configuration
- **Macro:** `DISPLAY_SCAN_SIGNED_EN`.
- **Defined:**
  - `value` is two's complement. The magnitude (|value|, DATA_W-bit unsigned, so the most negative value converts correctly) is converted.
  - If negative, '-' is shown on the digit immediately left of the most significant displayed digit.
  - If the magnitude needs all DIGITS digits, `ovf`=1.
  - Negative zero cannot occur.
- **Undefined:** `value` is unsigned. No sign logic is present.

## Test plan
- **Reset:** assert `rst_n`=0 mid-scan → `an`=4'b1111, `seg`=7'h7F, `busy`=0 immediately. After release, digit 0 shows 1000000 and `an[3:1]` stay high.
- **Conversion (DIGITS=4, DATA_W=8):** load 8'd255 → `busy` high exactly 8 cycles. Then `an[0]`→0010010 ("5"), `an[1]`→0010010 ("5"), `an[2]`→0100100 ("2"), `an[3]` blank, `ovf`=0.
- **Load while busy:** load 8'd7, then load 8'd99 two cycles later → display settles at "7". The second load has no effect.
- **Overflow (DIGITS=2):** load 8'd100 → `ovf`=1, both digits 0111111. Then load 8'd42 → `ovf`=0, display "42".
- **Scan (SCAN_DIV=4, DIGITS=4):** count over 64 cycles → each anode low for exactly 12 cycles. Every cycle with `cnt`=0 has all anodes high. Never more than one anode low.
- **Signed, macro defined (DIGITS=4):**
  - Load 8'hFB → "-5": `an[1]`=0111111, `an[0]`=0010010.
  - Load 8'h80 → "-128".
  - Same case with DIGITS=3 → `ovf`=1.
